histogram_median_reader: RTL
============================

Name: histogram_median_reader

Overview:
- Consumer end of the histogram readout interface. The block requests histogram readouts from the histogram engine and captures the streamed X and Y bins.
- It computes the median X and Y coordinate of all set pixels, giving the filtered object position.
- It works in two readout passes:
  - Pass 1 totals each axis.
  - Pass 2 finds the first bin where the cumulative count reaches half of the total.
- It sits between the histogram engine and the downstream position/overlay logic.

Parameters:
IMWIDTH, 240, number of X bins accepted per pass
IMHEIGHT, 180, number of Y bins accepted per pass
BIN_W, 8, width of one streamed bin value
SUM_W, 16, width of totals/cumulative sums (must hold IMWIDTH*(2^BIN_W-1))
TIMEOUT, 1023, max cycles waiting for engine accept/finish before error

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to compute medians; ignored while busy
histReady  in  1  engine ready (high = engine idle)
xHistIn  in  BIN_W  streamed X bin value
yHistIn  in  BIN_W  streamed Y bin value
xValidIn  in  1  X bin beat valid
yValidIn  in  1  Y bin beat valid
readHistogram  out  1  readout request to engine
xMedian  out  8  median X bin index
yMedian  out  8  median Y bin index
medianValid  out  1  one-cycle pulse when medians updated
empty  out  1  total pixel count was zero (held with medians)
busy  out  1  high from accepted start until DONE exits
error  out  1  timeout occurred (held until next accepted start)

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; all sums, counters and timer cleared. Reset mid-pass abandons the pass with no partial result.
- States: IDLE, REQ1, SUM, REQ2, SCAN, DONE.
- IDLE:
  - start=1 and histReady=1 -> REQ1; busy=1, error=0, sums/indices cleared.
  - start with histReady=0 is ignored.
- REQ1/REQ2:
  - Drive readHistogram=1.
  - On first cycle histReady=0 (engine accepted): deassert readHistogram next cycle; go to SUM/SCAN respectively.
- SUM (pass 1):
  - Each cycle xValidIn=1 and xIdx<IMWIDTH: xTotal += xHistIn, xIdx++. Y likewise with IMHEIGHT.
  - Beats past the bin count are ignored.
  - Pass ends when histReady returns 1. Then xThr=(xTotal+1)>>1, yThr likewise, indices reset -> REQ2.
- SCAN (pass 2):
  - On each valid beat: cum += bin.
  - If !found and cum+bin >= thr: median <= idx, found <= 1.
  - Pass ends when histReady=1 -> DONE.
- DONE (1 cycle):
  - medianValid=1, xMedian/yMedian/empty registered, busy=0 -> IDLE.
  - If an axis never set found (cannot occur with consistent passes), its median is the last index.
  - empty=1 iff xTotal==0; then medians=0.
- Timeout: a single timer counts cycles in REQ*/SUM/SCAN and resets on each state change or valid beat. Reaching TIMEOUT -> error=1, readHistogram=0, busy=0, IDLE, no medianValid.
- Sums saturate at 2^SUM_W-1 (no wrap).
- X and Y beats are handled independently: simultaneous or skewed valids are both allowed.
- Medians and empty hold until the next DONE.

Optional Feature:
- Macro MEDIAN_TOTALS_OUT_EN.
- When defined: adds outputs xTotalOut, yTotalOut (SUM_W each), registered in DONE alongside the medians and reset to 0.
- When undefined: those ports are absent and behaviour is otherwise identical.

Decomposition:
- Package histogram_median_pkg: state encoding, BIN_W/SUM_W defaults, IMWIDTH/IMHEIGHT constants shared with the histogram engine.
- Sub-module axis_median_accum (parameter NBINS), instanced once per axis. It contains the index counter, total, cumulative sum, threshold, found flag and median register, and takes phase inputs (clear, sum, scan, latch).

Test Plan:
- X bins all 0 except bin 100=4; Y bin 50=4 -> xMedian=100, yMedian=50, empty=0, one medianValid pulse.
- X bins 10=1, 20=1, 30=1 (total 3, thr 2) -> xMedian=20. X bins 10=2, 20=2 (total 4, thr 2) -> xMedian=10.
- All bins zero -> empty=1, xMedian=0, yMedian=0, medianValid pulses.
- histReady held 1 after request (engine never accepts) -> error=1 after TIMEOUT cycles, busy=0, no medianValid; next start clears error.
- Assert reset during SCAN -> all outputs 0 immediately, state IDLE. A following start completes a normal result.
- Every X bin =255 for 240 bins -> xTotal=61200 without wrap, xMedian=119. With MEDIAN_TOTALS_OUT_EN, xTotalOut=61200.

Source files
------------

// File: rtl/histogram_median_pkg.sv
// ---------------------------------------------------------------------------
// histogram_median_pkg
// Shared constants and types for the histogram median reader.
//   HM_IMWIDTH / HM_IMHEIGHT : number of X / Y bins streamed by the histogram
//                              engine per readout (must match the engine)
//   HM_BIN_W                 : width of one streamed bin value
//   HM_SUM_W                 : width of totals / cumulative sums
//   HM_TIMEOUT               : default cycles to wait on the engine before error
//   HM_MEDIAN_W              : width of the reported median bin index
//   hmState_t                : reader controller state encoding
// ---------------------------------------------------------------------------
package histogram_median_pkg;

    localparam int HM_IMWIDTH  = 240;
    localparam int HM_IMHEIGHT = 180;
    localparam int HM_BIN_W    = 8;
    localparam int HM_SUM_W    = 16;
    localparam int HM_TIMEOUT  = 1023;
    localparam int HM_MEDIAN_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ1 = 3'd1,
        SUM  = 3'd2,
        REQ2 = 3'd3,
        SCAN = 3'd4,
        DONE = 3'd5
    } hmState_t;

    // States in which the controller is waiting on the engine and the
    // watchdog timer runs.
    function automatic logic isWaitState(input hmState_t s);
        return (s == REQ1) || (s == SUM) || (s == REQ2) || (s == SCAN);
    endfunction

endpackage

// File: rtl/histogram_median_reader_if.sv
// ---------------------------------------------------------------------------
// histogram_median_reader_if
// Histogram readout bus between the histogram engine and its consumer.
//   readHistogram : consumer -> engine, readout request
//   histReady     : engine -> consumer, high while the engine is idle
//   xHistIn/yHistIn   : engine -> consumer, streamed bin values (BIN_W)
//   xValidIn/yValidIn : engine -> consumer, per-axis beat valid
// Modports:
//   master : engine side (drives bins/valids/ready, receives the request)
//   slave  : consumer side (histogram_median_reader)
// ---------------------------------------------------------------------------
interface histogram_median_reader_if #(
    parameter int BIN_W = 8
);
    logic             readHistogram;
    logic             histReady;
    logic [BIN_W-1:0] xHistIn;
    logic [BIN_W-1:0] yHistIn;
    logic             xValidIn;
    logic             yValidIn;

    modport master (
        input  readHistogram,
        output histReady,
        output xHistIn,
        output yHistIn,
        output xValidIn,
        output yValidIn
    );

    modport slave (
        output readHistogram,
        input  histReady,
        input  xHistIn,
        input  yHistIn,
        input  xValidIn,
        input  yValidIn
    );
endinterface

// File: rtl/axis_median_accum.sv
// ---------------------------------------------------------------------------
// axis_median_accum
// Per-axis datapath of the median reader. Pass 1 totals the streamed bins,
// pass 2 walks them again and records the first bin index at which the
// cumulative count reaches ceil(total/2).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : start of a new measurement, clears everything
//   sumEn      : pass-1 phase, valid beats are added to the total
//   latch      : end of pass 1, threshold computed, index/cumulative rewound
//   scanEn     : pass-2 phase, valid beats advance the cumulative search
//   validIn    : bin beat valid
//   binIn      : bin value (BIN_W)
//   total      : saturating total of pass 1 (SUM_W)
//   median     : found bin index, or the last bin index if never found
// Beats beyond NBINS in either pass are ignored.
// ---------------------------------------------------------------------------
module axis_median_accum
    import histogram_median_pkg::*;
#(
    parameter int NBINS = HM_IMWIDTH,
    parameter int BIN_W = HM_BIN_W,
    parameter int SUM_W = HM_SUM_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   sumEn,
    input  logic                   latch,
    input  logic                   scanEn,
    input  logic                   validIn,
    input  logic [BIN_W-1:0]       binIn,
    output logic [SUM_W-1:0]       total,
    output logic [HM_MEDIAN_W-1:0] median
);

    localparam int IDX_W = $clog2(NBINS + 1);
    localparam int SW1   = SUM_W + 1;
    localparam logic [IDX_W-1:0] NBINS_IDX = IDX_W'(NBINS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBINS - 1);

    logic [IDX_W-1:0] idxReg;
    logic [IDX_W-1:0] medianReg;
    logic [SUM_W-1:0] totalReg;
    logic [SUM_W-1:0] cumReg;
    logic [SUM_W-1:0] thrReg;
    logic             foundReg;

    logic             beatOk;
    logic [SUM_W:0]   totalSum;
    logic [SUM_W:0]   cumSum;
    logic [SUM_W-1:0] totalSat;
    logic [SUM_W-1:0] cumSat;
    logic [SUM_W-1:0] thrNext;

    assign beatOk = validIn && (idxReg < NBINS_IDX);

    // One extra bit of headroom detects overflow; sums stick at all-ones.
    assign totalSum = {1'b0, totalReg} + SW1'(binIn);
    assign cumSum   = {1'b0, cumReg} + SW1'(binIn);
    assign totalSat = totalSum[SUM_W] ? '1 : totalSum[SUM_W-1:0];
    assign cumSat   = cumSum[SUM_W] ? '1 : cumSum[SUM_W-1:0];

    // ceil(total/2) written so it cannot overflow even at a saturated total.
    assign thrNext = (totalReg >> 1) + SUM_W'(totalReg[0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idxReg    <= '0;
            medianReg <= '0;
            totalReg  <= '0;
            cumReg    <= '0;
            thrReg    <= '0;
            foundReg  <= 1'b0;
        end else if (clear) begin
            idxReg    <= '0;
            medianReg <= '0;
            totalReg  <= '0;
            cumReg    <= '0;
            thrReg    <= '0;
            foundReg  <= 1'b0;
        end else if (latch) begin
            thrReg   <= thrNext;
            idxReg   <= '0;
            cumReg   <= '0;
            foundReg <= 1'b0;
        end else if (sumEn && beatOk) begin
            totalReg <= totalSat;
            idxReg   <= idxReg + IDX_W'(1);
        end else if (scanEn && beatOk) begin
            cumReg <= cumSat;
            idxReg <= idxReg + IDX_W'(1);
            // Compare against the unsaturated cum+bin so the bin that
            // crosses the threshold is the one reported.
            if (!foundReg && (cumSum >= {1'b0, thrReg})) begin
                medianReg <= idxReg;
                foundReg  <= 1'b1;
            end
        end
    end

    assign total  = totalReg;
    assign median = foundReg ? HM_MEDIAN_W'(medianReg) : HM_MEDIAN_W'(LAST_IDX);

endmodule

// File: rtl/histogram_median_reader.sv
// ---------------------------------------------------------------------------
// histogram_median_reader
// Consumer end of the histogram readout bus. On start it requests two
// readouts from the histogram engine: the first totals each axis, the second
// finds the first bin where the cumulative count reaches half the total.
// The resulting X/Y medians give the filtered object position.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   start          : one-cycle request (ignored while busy or engine not ready)
//   hist (slave)   : readout bus (readHistogram out; histReady, bins, valids in)
//   xMedian/yMedian: median bin indices, held until the next result
//   medianValid    : one-cycle pulse coincident with updated medians/empty
//   empty          : total X pixel count was zero (medians forced to 0)
//   busy           : measurement in progress
//   error          : engine watchdog expired, held until the next accepted start
// Optional build macro MEDIAN_TOTALS_OUT_EN adds xTotalOut/yTotalOut (SUM_W),
// registered together with the medians.
// ---------------------------------------------------------------------------
module histogram_median_reader
    import histogram_median_pkg::*;
#(
    parameter int IMWIDTH  = HM_IMWIDTH,
    parameter int IMHEIGHT = HM_IMHEIGHT,
    parameter int BIN_W    = HM_BIN_W,
    parameter int SUM_W    = HM_SUM_W,
    parameter int TIMEOUT  = HM_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    histogram_median_reader_if.slave  hist,
    output logic [HM_MEDIAN_W-1:0]    xMedian,
    output logic [HM_MEDIAN_W-1:0]    yMedian,
    output logic                      medianValid,
    output logic                      empty,
    output logic                      busy,
    output logic                      error
`ifdef MEDIAN_TOTALS_OUT_EN
    ,
    output logic [SUM_W-1:0]          xTotalOut,
    output logic [SUM_W-1:0]          yTotalOut
`endif
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    hmState_t             stateReg;
    hmState_t             stateNext;
    logic [TIMER_W-1:0]   timerReg;
    logic [TIMER_W-1:0]   timerNext;
    logic                 timeoutHit;

    logic                 accClear;
    logic                 sumEn;
    logic                 latchThr;
    logic                 scanEn;
    logic                 anyBeat;
    logic                 waiting;

    logic [SUM_W-1:0]       axisTotal  [2];
    logic [HM_MEDIAN_W-1:0] axisMedian [2];

    logic [HM_MEDIAN_W-1:0] xMedianReg;
    logic [HM_MEDIAN_W-1:0] yMedianReg;
    logic                   medianValidReg;
    logic                   emptyReg;
    logic                   errorReg;
    logic                   xEmpty;
    logic                   yEmpty;

    // ------------------------------------------------------------------
    // Phase strobes for the per-axis datapaths. Beats are only taken while
    // the engine reports itself busy so both passes see the same stream.
    // ------------------------------------------------------------------
    assign accClear = (stateReg == IDLE) && start && hist.histReady;
    assign sumEn    = (stateReg == SUM)  && !hist.histReady;
    assign latchThr = (stateReg == SUM)  && hist.histReady;
    assign scanEn   = (stateReg == SCAN) && !hist.histReady;
    assign anyBeat  = hist.xValidIn || hist.yValidIn;
    assign waiting  = isWaitState(stateReg);

    // ------------------------------------------------------------------
    // Axis datapaths: index 0 is X, index 1 is Y.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : gAxis
        axis_median_accum #(
            .NBINS (gi == 0 ? IMWIDTH : IMHEIGHT),
            .BIN_W (BIN_W),
            .SUM_W (SUM_W)
        ) uAccum (
            .clk     (clk),
            .reset   (reset),
            .clear   (accClear),
            .sumEn   (sumEn),
            .latch   (latchThr),
            .scanEn  (scanEn),
            .validIn (gi == 0 ? hist.xValidIn : hist.yValidIn),
            .binIn   (gi == 0 ? hist.xHistIn : hist.yHistIn),
            .total   (axisTotal[gi]),
            .median  (axisMedian[gi])
        );
    end

    // ------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
            timerReg <= '0;
        end else begin
            stateReg <= stateNext;
            timerReg <= timerNext;
        end
    end

    // ------------------------------------------------------------------
    // Controller: next state and watchdog. The timer restarts on every
    // state change and every valid beat, so it only measures stalls.
    // ------------------------------------------------------------------
    always_comb begin
        stateNext  = stateReg;
        timerNext  = '0;
        timeoutHit = 1'b0;

        case (stateReg)
            IDLE: if (start && hist.histReady)  stateNext = REQ1;
            REQ1: if (!hist.histReady)          stateNext = SUM;
            SUM:  if (hist.histReady)           stateNext = REQ2;
            REQ2: if (!hist.histReady)          stateNext = SCAN;
            SCAN: if (hist.histReady)           stateNext = DONE;
            DONE:                               stateNext = IDLE;
            default:                            stateNext = IDLE;
        endcase

        if (waiting && (stateNext == stateReg) && !anyBeat) begin
            if (timerReg == TIMER_LAST) begin
                timeoutHit = 1'b1;
                stateNext  = IDLE;
            end else begin
                timerNext = timerReg + TIMER_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Result registers. They load on the DONE cycle so medianValid rises
    // together with the new values (the cycle after DONE).
    // ------------------------------------------------------------------
    assign xEmpty = (axisTotal[0] == '0);
    assign yEmpty = (axisTotal[1] == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xMedianReg     <= '0;
            yMedianReg     <= '0;
            medianValidReg <= 1'b0;
            emptyReg       <= 1'b0;
            errorReg       <= 1'b0;
        end else begin
            medianValidReg <= (stateReg == DONE);

            if (stateReg == DONE) begin
                emptyReg   <= xEmpty;
                xMedianReg <= xEmpty ? '0 : axisMedian[0];
                // An axis without pixels reports bin 0 rather than the
                // threshold-0 hit of the scan.
                yMedianReg <= (xEmpty || yEmpty) ? '0 : axisMedian[1];
            end

            if (accClear) begin
                errorReg <= 1'b0;
            end else if (timeoutHit) begin
                errorReg <= 1'b1;
            end
        end
    end

`ifdef MEDIAN_TOTALS_OUT_EN
    logic [SUM_W-1:0] xTotalOutReg;
    logic [SUM_W-1:0] yTotalOutReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xTotalOutReg <= '0;
            yTotalOutReg <= '0;
        end else if (stateReg == DONE) begin
            xTotalOutReg <= axisTotal[0];
            yTotalOutReg <= axisTotal[1];
        end
    end

    assign xTotalOut = xTotalOutReg;
    assign yTotalOut = yTotalOutReg;
`endif

    assign hist.readHistogram = (stateReg == REQ1) || (stateReg == REQ2);
    assign busy               = (stateReg != IDLE);
    assign xMedian            = xMedianReg;
    assign yMedian            = yMedianReg;
    assign medianValid        = medianValidReg;
    assign empty              = emptyReg;
    assign error              = errorReg;

endmodule
